// File: rtl/cam_stream_gen.sv
// OV7670-style RGB444 camera source: pclk/vsync/href/data for solid, bars, checker and ramp frames.
// Stream outputs are registered on pclk falling ticks; free-running source, no backpressure.
module cam_stream_gen #(
  parameter int PCLK_DIV    = 2,
  parameter int LINE_PIXELS = 160,
  parameter int ROWS        = 120,
  parameter int HBLANK      = 4,
  parameter int VBLANK_ROWS = 4,
  parameter int VSYNC_ROWS  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [11:0] color,
  output logic        CAM_pclk,
  output logic        CAM_vsync,
  output logic        CAM_href,
  output logic [7:0]  CAM_px_data,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam int LB    = 2 * LINE_PIXELS;
  localparam int COLS  = LB + HBLANK;
  localparam int LINES = VBLANK_ROWS + ROWS;
  localparam int COL_W = $clog2(COLS) + 1;
  localparam int ROW_W = $clog2(LINES) + 1;
  localparam int DIV_W = $clog2(PCLK_DIV) + 1;

  localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(PCLK_DIV - 1);
  localparam logic [COL_W-1:0] COL_MAX   = COL_W'(COLS - 1);
  localparam logic [COL_W-1:0] LB_C      = COL_W'(LB);
  localparam logic [ROW_W-1:0] ROW_MAX   = ROW_W'(LINES - 1);
  localparam logic [ROW_W-1:0] VB_R      = ROW_W'(VBLANK_ROWS);
  localparam logic [ROW_W-1:0] VS_R      = ROW_W'(VSYNC_ROWS);
  localparam logic [ROW_W-1:0] Y8        = ROW_W'(8);
  localparam logic [COL_W-2:0] X8        = (COL_W-1)'(8);
  localparam logic [COL_W-2:0] BAR_PIX   = (COL_W-1)'(LINE_PIXELS / 8);
  localparam logic [7:0]       LB8       = 8'(LB);

  typedef enum logic [1:0] {IDLE, FRAME, DONE} state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [1:0]       mode_q;
  logic [11:0]      color_q;

  logic             pclk_edge, fall_tick, start, last;
  logic [ROW_W-1:0] emit_row, y;
  logic [COL_W-1:0] emit_col;
  logic [COL_W-2:0] x, bar_q;
  logic [1:0]       emit_mode;
  logic [11:0]      emit_color, pix;
  logic             vsync_n, href_n;
  logic [7:0]       byte_n, ramp;

  assign pclk_edge = (div_cnt == DIV_MAX);
  assign fall_tick = pclk_edge && CAM_pclk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt  <= '0;
      CAM_pclk <= 1'b0;
    end else begin
      div_cnt <= pclk_edge ? '0 : div_cnt + 1'b1;
      if (pclk_edge) CAM_pclk <= ~CAM_pclk;
    end
  end

  // A frame start emits slot (0,0) on the same tick, using the live mode/color.
  assign start      = fall_tick && en && (state != FRAME);
  assign emit_row   = start ? '0 : row;
  assign emit_col   = start ? '0 : col;
  assign emit_mode  = start ? mode : mode_q;
  assign emit_color = start ? color : color_q;
  assign last       = (emit_row == ROW_MAX) && (emit_col == COL_MAX);

  assign x       = emit_col[COL_W-1:1];
  assign y       = emit_row - VB_R;
  assign bar_q   = x / BAR_PIX;
  assign vsync_n = (emit_row < VS_R);
  assign href_n  = (emit_row >= VB_R) && (emit_col < LB_C);
  assign ramp    = 8'(y) * LB8 + 8'(emit_col);

  always_comb begin
    pix = '0;
    case (emit_mode)
      2'd0: pix = emit_color;
      2'd1: begin
        case (3'(bar_q))
          3'd0:    pix = 12'hFFF;
          3'd1:    pix = 12'hFF0;
          3'd2:    pix = 12'h0FF;
          3'd3:    pix = 12'h0F0;
          3'd4:    pix = 12'hF0F;
          3'd5:    pix = 12'hF00;
          3'd6:    pix = 12'h00F;
          default: pix = 12'h000;
        endcase
      end
      2'd2: pix = (((x & X8) != '0) ^ ((y & Y8) != '0)) ? emit_color : 12'h000;
      default: pix = '0;
    endcase
  end

  always_comb begin
    byte_n = 8'h00;
    if (href_n) begin
      if (emit_mode == 2'd3) byte_n = ramp;
      else if (emit_col[0])  byte_n = pix[7:0];
      else                   byte_n = {4'h0, pix[11:8]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      row         <= '0;
      col         <= '0;
      mode_q      <= '0;
      color_q     <= '0;
      CAM_vsync   <= 1'b0;
      CAM_href    <= 1'b0;
      CAM_px_data <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      frame_done <= 1'b0;
      if (fall_tick) begin
        if (state == DONE) begin
          frame_done <= 1'b1;
          frame_cnt  <= frame_cnt + 16'd1;
        end
        if (start || state == FRAME) begin
          CAM_vsync   <= vsync_n;
          CAM_href    <= href_n;
          CAM_px_data <= byte_n;
          busy        <= 1'b1;
          mode_q      <= emit_mode;
          color_q     <= emit_color;
          if (last) begin
            state <= DONE;
            row   <= '0;
            col   <= '0;
          end else begin
            state <= FRAME;
            if (emit_col == COL_MAX) begin
              col <= '0;
              row <= emit_row + 1'b1;
            end else begin
              col <= emit_col + 1'b1;
              row <= emit_row;
            end
          end
        end else begin
          CAM_vsync   <= 1'b0;
          CAM_href    <= 1'b0;
          CAM_px_data <= '0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_stream_gen.sv
// Scoreboard bench for cam_stream_gen using a reduced frame geometry.
module tb_cam_stream_gen;

  localparam int PCLK_DIV = 2;
  localparam int LP       = 16;
  localparam int ROWS     = 10;
  localparam int HB       = 4;
  localparam int VB       = 4;
  localparam int VS       = 2;
  localparam int LB       = 2 * LP;
  localparam int COLS     = LB + HB;
  localparam int LINES    = VB + ROWS;
  localparam int SLOTS    = COLS * LINES;
  localparam int FRAME_CLK = SLOTS * 2 * PCLK_DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic [11:0] color;
  logic        CAM_pclk, CAM_vsync, CAM_href, busy, frame_done;
  logic [7:0]  CAM_px_data;
  logic [15:0] frame_cnt;

  int          total = 0;
  int          bad   = 0;
  logic [9:0]  sb[$];
  logic [15:0] exp_cnt;
  int          pops;
  logic        last_pclk, last_fd;
  logic [9:0]  exp_slot;

  always #5 clk = ~clk;

  cam_stream_gen #(
    .PCLK_DIV(PCLK_DIV), .LINE_PIXELS(LP), .ROWS(ROWS),
    .HBLANK(HB), .VBLANK_ROWS(VB), .VSYNC_ROWS(VS)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .color(color),
    .CAM_pclk(CAM_pclk), .CAM_vsync(CAM_vsync), .CAM_href(CAM_href),
    .CAM_px_data(CAM_px_data), .busy(busy), .frame_done(frame_done),
    .frame_cnt(frame_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  // Bar colours: R on for bars 0,1,4,5; G on for bars 0..3; B on for even bars.
  function automatic logic [11:0] bar_rgb(input int i);
    logic [3:0] r, g, b;
    r = ((i / 2) % 2 == 0) ? 4'hF : 4'h0;
    g = (i < 4) ? 4'hF : 4'h0;
    b = (i % 2 == 0) ? 4'hF : 4'h0;
    return {r, g, b};
  endfunction

  function automatic logic [7:0] ref_byte(input int m, input logic [11:0] c, input int row, input int col);
    int x, y;
    logic [11:0] p;
    x = col / 2;
    y = row - VB;
    if (m == 3) return 8'((y * LB + col) % 256);
    if (m == 0)      p = c;
    else if (m == 1) p = bar_rgb(x / (LP / 8));
    else             p = (((x / 8) + (y / 8)) % 2 == 1) ? c : 12'h000;
    return (col % 2 == 0) ? {4'h0, p[11:8]} : p[7:0];
  endfunction

  task automatic push_frame(input int m, input logic [11:0] c);
    logic vs, hr;
    logic [7:0] d;
    for (int r = 0; r < LINES; r++) begin
      for (int cc = 0; cc < COLS; cc++) begin
        vs = (r < VS);
        hr = (r >= VB) && (cc < LB);
        d  = hr ? ref_byte(m, c, r, cc) : 8'h00;
        sb.push_back({vs, hr, d});
      end
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    logic seen;
    n = 0;
    seen = 1'b0;
    while (n < budget && !seen) begin
      @(negedge clk);
      n++;
      if (frame_done) seen = 1'b1;
    end
    check("frame_done_timeout", seen, 1);
  endtask

  task automatic wait_busy(input int budget);
    int n;
    n = 0;
    while (n < budget && !busy) begin
      @(negedge clk);
      n++;
    end
    check("busy_timeout", busy, 1);
  endtask

  task automatic pclk_rise_gap(output int n);
    logic lp;
    lp = CAM_pclk;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (CAM_pclk && !lp) break;
      lp = CAM_pclk;
    end
  endtask

  // Monitor: one slot per pclk rising edge while busy; idle slots must be quiet.
  always @(negedge clk) begin
    if (!rst) begin
      last_pclk = 1'b0;
      last_fd   = 1'b0;
      pops      = 0;
    end else begin
      if (CAM_pclk && !last_pclk) begin
        if (busy) begin
          check("sb_nonempty", (sb.size() != 0), 1);
          if (sb.size() != 0) begin
            exp_slot = sb.pop_front();
            check("slot", {CAM_vsync, CAM_href, CAM_px_data}, exp_slot);
            pops++;
          end
        end else begin
          check("idle_out", {CAM_vsync, CAM_href, CAM_px_data}, 0);
        end
      end
      if (frame_done) begin
        check("fd_width", last_fd, 0);
        exp_cnt = exp_cnt + 16'd1;
        check("frame_cnt", frame_cnt, exp_cnt);
        check("slots_per_frame", pops, SLOTS);
        pops = 0;
      end
      last_pclk = CAM_pclk;
      last_fd   = frame_done;
    end
  end

  initial begin
    int n1, n2;
    logic [1:0]  fm;
    logic [11:0] fc;
    rst = 1'b0;
    en = 1'b1;
    mode = 2'd0;
    color = 12'hA5C;
    exp_cnt = 16'd0;
    push_frame(0, 12'hA5C);

    repeat (10) begin
      @(negedge clk);
      check("rst_outs", {CAM_pclk, CAM_vsync, CAM_href, CAM_px_data, busy, frame_done}, 0);
      check("rst_cnt", frame_cnt, 0);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    pclk_rise_gap(n1);
    pclk_rise_gap(n2);
    check("pclk_period", n2, 2 * PCLK_DIV);

    // Each next frame's mode/color is applied mid-way through the current one.
    for (int k = 1; k < 8; k++) begin
      repeat (1000) @(posedge clk);
      #1;
      case (k)
        1: begin fm = 2'd1; fc = 12'($urandom); end
        2: begin fm = 2'd2; fc = 12'hFFF; end
        3: begin fm = 2'd3; fc = 12'($urandom); end
        default: begin fm = 2'($urandom_range(0, 3)); fc = 12'($urandom); end
      endcase
      mode = fm;
      color = fc;
      push_frame(fm, fc);
      if (k == 4) begin
        force dut.frame_cnt = 16'hFFFF;
        @(posedge clk);
        #1 release dut.frame_cnt;
        exp_cnt = 16'hFFFF;
      end
      wait_done(FRAME_CLK + 100);
    end

    repeat (1000) @(posedge clk);
    #1 en = 1'b0;
    mode = 2'($urandom);
    color = 12'($urandom);
    wait_done(FRAME_CLK + 100);
    repeat (40) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_href", CAM_href, 0);
    check("final_cnt", frame_cnt, 16'd4);
    check("sb_drained", sb.size(), 0);

    en = 1'b1;
    mode = 2'd2;
    color = 12'($urandom);
    push_frame(2, color);
    wait_busy(100);
    repeat (7 * COLS * 2 * PCLK_DIV) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("async_rst_outs", {CAM_pclk, CAM_vsync, CAM_href, CAM_px_data, busy, frame_done}, 0);
    check("async_rst_cnt", frame_cnt, 0);
    sb.delete();
    exp_cnt = 16'd0;
    mode = 2'd0;
    color = 12'($urandom);
    push_frame(0, color);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    wait_busy(100);
    check("restart_vsync", CAM_vsync, 1);
    repeat (1000) @(posedge clk);
    #1 en = 1'b0;
    wait_done(FRAME_CLK + 100);
    repeat (40) @(negedge clk);
    check("end_busy", busy, 0);
    check("end_cnt", frame_cnt, 16'd1);
    check("end_sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
